seg_interp_ctrl: RTL and testbench
==================================

// Module: seg_interp_ctrl
// PURPOSE
//   Piecewise-linear interpolation sequencer. Accepts a stream of control points and emits
//   X_DISPLACEMENT evenly spaced samples per segment. It owns one internal gen_delta instance
//   (identical parameters) that turns |y1-y0| into a fixed-point step. Sits between the
//   control-point source and the downstream sample consumer of the linear-transformation path.
// PARAMETERS
//   X_DISPLACEMENT  16  samples per segment; power of two, >=2 (gen_delta reciprocal exact only then)
//   DSIZE           16  point/sample width, unsigned
//   DT_I            8   integer bits of delta
//   DT_D            4   fractional bits of delta
// PORTS
//   clock          in   1      single clock, all logic on posedge
//   rst_n          in   1      synchronous, active-low reset
//   pt_valid       in   1      control point valid
//   pt_ready       out  1      controller can accept a point
//   pt_data        in   DSIZE  control point y value, unsigned
//   pt_last        in   1      this point ends the stream (flush after its segment)
//   out_valid      out  1      sample valid
//   out_ready      in   1      consumer accepts sample
//   out_data       out  DSIZE  interpolated sample
//   out_first      out  1      sample is k=0 of a segment (or a lone/tail point)
//   busy           out  1      state != S_IDLE
// BEHAVIOUR
//   - Reset (rst_n=0 at posedge): state=S_IDLE, out_valid=0, out_first=0, pt_ready=1 (comb), busy=0,
//     y0/y1/disp_q/delta_q/accum/k/wait_cnt=0. Reset mid-segment discards all state; no further output.
//   - Handshakes: transfer when valid&ready at posedge. out_valid, once high, stays high and
//     out_data/out_first stay stable until accepted. pt_ready=1 only in S_IDLE and S_ANCHOR.
//   - States:
//     S_IDLE:   accept point -> y0<=pt_data; pt_last ? S_TAIL : S_ANCHOR.
//     S_ANCHOR: accept point -> y1<=pt_data, last_q<=pt_last, disp_q<=|pt_data-y0|,
//               dir<=(pt_data<y0), wait_cnt<=0 -> S_CALC.
//     S_CALC:   disp_q drives gen_delta.y_displacement, held stable. gen_delta latency 2 edges;
//               on the 3rd edge after acceptance: delta_q<=delta, accum<={y0,DT_D'b0}, k<=0 -> S_RUN.
//               First out_valid of the segment is therefore high 3 edges after the accepting edge.
//     S_RUN:    out_valid=1, out_data=clamp(accum integer part), out_first=(k==0).
//               On accept: accum<=accum +/- delta_q (dir), k<=k+1.
//               On accept with k==X_DISPLACEMENT-1: y0<=y1; last_q ? S_TAIL : S_ANCHOR.
//     S_TAIL:   out_valid=1, out_data=y0, out_first=1; on accept -> S_IDLE.
//   - Arithmetic: accum signed, DSIZE+2 integer bits + DT_D fractional bits. delta_q is unsigned
//     DT_I.DT_D, zero-extended. Clamp: accum<0 -> 0; accum>2^DSIZE-1 -> 2^DSIZE-1.
//     gen_delta saturates delta to all ones when slope overflows DT_I; clamp handles the overshoot.
//   - Drift: delta is truncated, so samples may undershoot. Each new segment restarts exactly
//     at its anchor (accum reloaded from y0); error never accumulates across segments.
//   - y1==y0: disp=0, delta=0, X_DISPLACEMENT copies of y0.
//   - pt_valid in S_CALC/S_RUN/S_TAIL is held off (pt_ready=0); the point is not consumed.
//   - Only the first point after reset or after a flush starts a stream. Subsequent points are
//     anchors; every point is both the end of one segment and the start of the next.
// TESTING (defaults; out_ready=1 unless stated)
//   1 Points 0,160(last) -> delta=0x0A0; out 0,10,20..150 (out_first on 0), then tail 160, busy=0.
//   2 Points 160,0(last) -> dir=down; out 160,150..10, then tail 0.
//   3 Points 0,65535 -> delta saturates 0xFFF (255.9375); out floor(k*255.9375): 0,255,511..3839;
//     next segment starts at 65535.
//   4 Points 0,1,1(last) -> delta=0x001; 16x 0, then 16x 1, then tail 1.
//   5 Backpressure: out_ready=0 for 5 cycles at k=3 of test 1 -> out_data=30 held, no skip or repeat;
//     pt_valid asserted throughout -> pt_ready=0 until S_ANCHOR.
//   6 Lone point 42 with pt_last -> single sample 42, out_first=1. rst_n=0 at k=7 of test 1 ->
//     out_valid=0 next cycle, S_IDLE; restart with fresh points behaves like test 1.

Source files
------------

// File: rtl/seg_interp_ctrl.sv
// Piecewise-linear interpolation sequencer.
// Emits X_DISPLACEMENT evenly spaced samples per segment.
//
// Ports:
//   clock, rst_n        clock, synchronous active-low reset
//   pt_valid/pt_ready   control point handshake
//   pt_data, pt_last    point y value, end-of-stream flag
//   out_valid/out_ready sample handshake
//   out_data, out_first sample value, first-of-segment flag
//   busy                controller not idle
module seg_interp_ctrl #(
  parameter int X_DISPLACEMENT = 16,
  parameter int DSIZE          = 16,
  parameter int DT_I           = 8,
  parameter int DT_D           = 4
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             pt_valid,
  output logic             pt_ready,
  input  logic [DSIZE-1:0] pt_data,
  input  logic             pt_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DSIZE-1:0] out_data,
  output logic             out_first,
  output logic             busy
);

  localparam int KW = $clog2(X_DISPLACEMENT);
  localparam int DW = DT_I + DT_D;
  localparam int IW = DSIZE + 2;
  localparam int AW = IW + DT_D;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ANCHOR,
    S_CALC,
    S_RUN,
    S_TAIL
  } state_t;

  state_t state, state_n;

  logic [DSIZE-1:0]     y0, y1;
  logic                 last_q, dir;
  logic [DSIZE-1:0]     disp_q, disp_abs;
  logic [DW-1:0]        delta, delta_q;
  logic signed [AW-1:0] accum, accum_n, delta_ext;
  logic signed [IW-1:0] acc_int;
  logic [DSIZE-1:0]     clamped;
  logic [KW-1:0]        k;
  logic [1:0]           wait_cnt;
  logic                 k_last, calc_done;

  gen_delta #(
    .X_DISPLACEMENT(X_DISPLACEMENT),
    .DSIZE         (DSIZE),
    .DT_I          (DT_I),
    .DT_D          (DT_D)
  ) u_gen_delta (
    .clock         (clock),
    .rst_n         (rst_n),
    .y_displacement(disp_q),
    .delta         (delta)
  );

  assign k_last    = (k == KW'(X_DISPLACEMENT - 1));
  // delta is ready two edges after disp_q settles
  assign calc_done = (wait_cnt == 2'd2);
  assign busy      = (state != S_IDLE);

  assign disp_abs = (pt_data >= y0) ? pt_data - y0
                                    : y0 - pt_data;

  assign delta_ext = {{(AW-DW){1'b0}}, delta_q};
  assign accum_n   = dir ? accum - delta_ext
                         : accum + delta_ext;
  assign acc_int   = accum[AW-1:DT_D];

  always_comb begin
    if (acc_int[IW-1])
      clamped = '0;
    else if (|acc_int[IW-2:DSIZE])
      clamped = '1;
    else
      clamped = acc_int[DSIZE-1:0];
  end

  always_ff @(posedge clock) begin
    if (!rst_n)
      state <= S_IDLE;
    else
      state <= state_n;
  end

  always_comb begin
    state_n   = state;
    pt_ready  = 1'b0;
    out_valid = 1'b0;
    out_first = 1'b0;
    out_data  = '0;
    unique case (state)
      S_IDLE: begin
        pt_ready = 1'b1;
        if (pt_valid)
          state_n = pt_last ? S_TAIL : S_ANCHOR;
      end
      S_ANCHOR: begin
        pt_ready = 1'b1;
        if (pt_valid)
          state_n = S_CALC;
      end
      S_CALC: begin
        if (calc_done)
          state_n = S_RUN;
      end
      S_RUN: begin
        out_valid = 1'b1;
        out_data  = clamped;
        out_first = (k == '0);
        if (out_ready && k_last)
          state_n = last_q ? S_TAIL : S_ANCHOR;
      end
      S_TAIL: begin
        out_valid = 1'b1;
        out_data  = y0;
        out_first = 1'b1;
        if (out_ready)
          state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      y0       <= '0;
      y1       <= '0;
      last_q   <= 1'b0;
      dir      <= 1'b0;
      disp_q   <= '0;
      delta_q  <= '0;
      accum    <= '0;
      k        <= '0;
      wait_cnt <= '0;
    end else begin
      if (state == S_IDLE && pt_valid)
        y0 <= pt_data;
      if (state == S_ANCHOR && pt_valid) begin
        y1       <= pt_data;
        last_q   <= pt_last;
        disp_q   <= disp_abs;
        dir      <= (pt_data < y0);
        wait_cnt <= '0;
      end
      if (state == S_CALC) begin
        wait_cnt <= wait_cnt + 2'd1;
        if (calc_done) begin
          delta_q <= delta;
          // each segment restarts exactly at its anchor
          accum   <= {2'b00, y0, {DT_D{1'b0}}};
          k       <= '0;
        end
      end
      if (state == S_RUN && out_ready) begin
        accum <= accum_n;
        k     <= k + 1'b1;
        if (k_last)
          y0 <= y1;
      end
    end
  end

endmodule

// Fixed-point slope: y_displacement / X_DISPLACEMENT
// as DT_I.DT_D, saturating, two-edge latency.
module gen_delta #(
  parameter int X_DISPLACEMENT = 16,
  parameter int DSIZE          = 16,
  parameter int DT_I           = 8,
  parameter int DT_D           = 4
) (
  input  logic                 clock,
  input  logic                 rst_n,
  input  logic [DSIZE-1:0]     y_displacement,
  output logic [DT_I+DT_D-1:0] delta
);

  localparam int SH = $clog2(X_DISPLACEMENT);
  localparam int DW = DT_I + DT_D;
  localparam int QW = DSIZE + DT_D;

  logic [QW-1:0] quot_q;

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      quot_q <= '0;
      delta  <= '0;
    end else begin
      // power-of-two divisor: shift is an exact floor
      quot_q <= {y_displacement, {DT_D{1'b0}}} >> SH;
      delta  <= (|quot_q[QW-1:DW]) ? '1
                                   : quot_q[DW-1:0];
    end
  end

endmodule

// File: tb/tb_seg_interp_ctrl.sv
// Directed bench for seg_interp_ctrl.
// Table of point streams with expected samples.
module tb_seg_interp_ctrl;

  logic        clock = 1'b0;
  logic        rst_n = 1'b0;
  logic        pt_valid = 1'b0;
  logic        pt_ready;
  logic [15:0] pt_data = '0;
  logic        pt_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_data;
  logic        out_first;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  seg_interp_ctrl dut (
    .clock    (clock),
    .rst_n    (rst_n),
    .pt_valid (pt_valid),
    .pt_ready (pt_ready),
    .pt_data  (pt_data),
    .pt_last  (pt_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_first(out_first),
    .busy     (busy)
  );

  typedef struct {
    int                np;
    logic [3:0][15:0]  p;
    logic [3:0]        l;
    int                ne;
    logic [33:0][16:0] ex;
    int                stall_at;
  } case_t;

  case_t cases[6];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d",
               nm, act, exp);
    end
  endtask

  task automatic send_pts(input int np,
                          input logic [3:0][15:0] p,
                          input logic [3:0] l);
    logic ok;
    for (int i = 0; i < np; i++) begin
      @(negedge clock);
      pt_valid = 1'b1;
      pt_data  = p[i];
      pt_last  = l[i];
      ok = 1'b0;
      for (int t = 0; t < 400; t++) begin
        if (pt_ready) ok = 1'b1;
        @(posedge clock);
        if (ok) break;
        @(negedge clock);
      end
      if (!ok) begin
        checks++;
        errors++;
        $display("FAIL pt_timeout point %0d", i);
      end
    end
    @(negedge clock);
    pt_valid = 1'b0;
    pt_last  = 1'b0;
  endtask

  task automatic collect(input string nm,
                         input int n,
                         input logic [33:0][16:0] ex,
                         input int stall_at);
    int idx = 0;
    int cyc = 0;
    while (idx < n && cyc < 600) begin
      @(negedge clock);
      cyc++;
      if (idx == stall_at && out_ready) begin
        out_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
          chk({nm, "_stall_valid"}, 32'(out_valid), 1);
          chk({nm, "_stall_data"}, 32'(out_data),
              32'(ex[idx][15:0]));
          chk({nm, "_stall_ptrdy"}, 32'(pt_ready), 0);
          @(negedge clock);
        end
        out_ready = 1'b1;
      end
      if (out_valid && out_ready) begin
        chk($sformatf("%s_data%0d", nm, idx),
            32'(out_data), 32'(ex[idx][15:0]));
        chk($sformatf("%s_first%0d", nm, idx),
            32'(out_first), 32'(ex[idx][16]));
        idx++;
      end
    end
    if (idx < n) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout got %0d want %0d",
               nm, idx, n);
    end
  endtask

  task automatic run_case(input int ci);
    string nm;
    nm = $sformatf("c%0d", ci);
    fork
      send_pts(cases[ci].np, cases[ci].p, cases[ci].l);
      collect(nm, cases[ci].ne, cases[ci].ex,
              cases[ci].stall_at);
    join
    @(posedge clock);
    #1;
    chk({nm, "_busy_end"}, 32'(busy), 0);
    chk({nm, "_ptrdy_end"}, 32'(pt_ready), 1);
  endtask

  initial begin
    int lat;

    // 0: up 0 -> 160
    cases[0].np = 2;
    cases[0].p  = {16'd0, 16'd0, 16'd160, 16'd0};
    cases[0].l  = 4'b0010;
    cases[0].ne = 17;
    cases[0].stall_at = -1;
    cases[0].ex = '0;
    for (int k = 0; k < 16; k++)
      cases[0].ex[k] = {k == 0, 16'(10 * k)};
    cases[0].ex[16] = {1'b1, 16'd160};

    // 1: down 160 -> 0
    cases[1].np = 2;
    cases[1].p  = {16'd0, 16'd0, 16'd0, 16'd160};
    cases[1].l  = 4'b0010;
    cases[1].ne = 17;
    cases[1].stall_at = -1;
    cases[1].ex = '0;
    for (int k = 0; k < 16; k++)
      cases[1].ex[k] = {k == 0, 16'(160 - 10 * k)};
    cases[1].ex[16] = {1'b1, 16'd0};

    // 2: saturated slope, then flat at 65535
    cases[2].np = 3;
    cases[2].p  = {16'd0, 16'd65535, 16'd65535, 16'd0};
    cases[2].l  = 4'b0100;
    cases[2].ne = 33;
    cases[2].stall_at = -1;
    cases[2].ex = '0;
    for (int k = 0; k < 16; k++) begin
      cases[2].ex[k]      = {k == 0, 16'((k * 4095) >> 4)};
      cases[2].ex[16 + k] = {k == 0, 16'd65535};
    end
    cases[2].ex[32] = {1'b1, 16'd65535};

    // 3: 0,1,1 tiny slope then zero slope
    cases[3].np = 3;
    cases[3].p  = {16'd0, 16'd1, 16'd1, 16'd0};
    cases[3].l  = 4'b0100;
    cases[3].ne = 33;
    cases[3].stall_at = -1;
    cases[3].ex = '0;
    for (int k = 0; k < 16; k++) begin
      cases[3].ex[k]      = {k == 0, 16'd0};
      cases[3].ex[16 + k] = {k == 0, 16'd1};
    end
    cases[3].ex[32] = {1'b1, 16'd1};

    // 4: lone point
    cases[4].np = 1;
    cases[4].p  = {16'd0, 16'd0, 16'd0, 16'd42};
    cases[4].l  = 4'b0001;
    cases[4].ne = 1;
    cases[4].stall_at = -1;
    cases[4].ex = '0;
    cases[4].ex[0] = {1'b1, 16'd42};

    // 5: backpressure at k=3, next stream held off
    cases[5].np = 3;
    cases[5].p  = {16'd0, 16'd42, 16'd160, 16'd0};
    cases[5].l  = 4'b0110;
    cases[5].ne = 18;
    cases[5].stall_at = 3;
    cases[5].ex = cases[0].ex;
    cases[5].ex[17] = {1'b1, 16'd42};

    repeat (3) @(posedge clock);
    #1;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_first", 32'(out_first), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ptrdy", 32'(pt_ready), 1);
    @(negedge clock);
    rst_n = 1'b1;

    // first-sample latency after the closing point
    send_pts(1, cases[0].p, 4'b0000);
    fork
      begin
        @(negedge clock);
        pt_valid = 1'b1;
        pt_data  = 16'd160;
        pt_last  = 1'b1;
        while (!pt_ready) @(negedge clock);
        @(posedge clock);
        #1;
        pt_valid = 1'b0;
        pt_last  = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
          @(posedge clock);
          lat++;
          #1;
        end
        chk("latency", 32'(lat), 3);
      end
    join
    collect("lat", 17, cases[0].ex, -1);
    @(posedge clock);
    #1;
    chk("lat_busy_end", 32'(busy), 0);

    for (int ci = 0; ci < 6; ci++)
      run_case(ci);

    // reset in the middle of a segment
    fork
      send_pts(2, cases[0].p, cases[0].l);
      collect("mid", 8, cases[0].ex, -1);
    join
    rst_n = 1'b0;
    @(posedge clock);
    #1;
    chk("midrst_valid", 32'(out_valid), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_ptrdy", 32'(pt_ready), 1);
    @(negedge clock);
    rst_n = 1'b1;
    repeat (4) @(posedge clock);
    #1;
    chk("midrst_quiet", 32'(out_valid), 0);
    run_case(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
